// File: rtl/bus_lv1_lv2_arb_proc.sv
// bus_lv1_lv2_arb_proc
// Per-core arbiter for the shared L1-to-L2 bus. The L1 instruction cache
// and the L1 data cache compete for it. Grants are mutually exclusive and
// are held for a whole transaction. Ownership alternates round-robin. One
// dead TURN cycle always separates two grants.
//
// Optional feature: define BUS_LV1_LV2_ARB_WDOG_EN to enable a hold
// watchdog. It forces a release after HOLD_MAX granted cycles and pulses
// arb_wdog_err during the resulting TURN cycle. In the default build the
// macro is undefined, so a grant may be held indefinitely and
// arb_wdog_err is tied low.
module bus_lv1_lv2_arb_proc #(
  parameter int HOLD_MAX = 64,
  parameter int CNT_WID  = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_lv1_lv2_req_proc_il,
  input  logic bus_lv1_lv2_req_proc_dl,
  output logic bus_lv1_lv2_gnt_proc_il,
  output logic bus_lv1_lv2_gnt_proc_dl,
  output logic bus_lv1_lv2_gnt_proc,
  output logic arb_last_gnt_dl,
  output logic arb_wdog_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IL = 2'd1,
    ST_GNT_DL = 2'd2,
    ST_TURN   = 2'd3
  } arb_state_e;

  arb_state_e state_q, state_d;
  logic       last_gnt_dl_q, last_gnt_dl_d;

  // This block only exists when the hold counter is too narrow to reach
  // HOLD_MAX-1. It therefore shows up in the elaborated hierarchy of a
  // misconfigured build.
  if ((HOLD_MAX < 1) || (HOLD_MAX >= (2 ** CNT_WID))) begin : g_invalid_hold_cfg
  end

`ifdef BUS_LV1_LV2_ARB_WDOG_EN
  localparam logic [CNT_WID-1:0] HOLD_LAST = CNT_WID'(HOLD_MAX - 1);

  logic [CNT_WID-1:0] hold_cnt_q, hold_cnt_d;
  logic               wdog_err_q, wdog_err_d;
  logic               hold_limit;

  assign hold_limit = (hold_cnt_q == HOLD_LAST);
`endif

  // State register plus the round-robin history and error flag, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_gnt_dl_q <= 1'b0;
`ifdef BUS_LV1_LV2_ARB_WDOG_EN
      wdog_err_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_gnt_dl_q <= last_gnt_dl_d;
`ifdef BUS_LV1_LV2_ARB_WDOG_EN
      wdog_err_q    <= wdog_err_d;
`endif
    end
  end

  // Next-state logic: arbitrate from IDLE/TURN, hold the grant while the owner keeps requesting
  always_comb begin
    state_d       = state_q;
    last_gnt_dl_d = last_gnt_dl_q;
`ifdef BUS_LV1_LV2_ARB_WDOG_EN
    wdog_err_d    = 1'b0;
`endif

    unique case (state_q)
      ST_GNT_IL: begin
        if (!bus_lv1_lv2_req_proc_il) begin
          state_d = ST_TURN;
        end
`ifdef BUS_LV1_LV2_ARB_WDOG_EN
        else if (hold_limit) begin
          state_d    = ST_TURN;
          wdog_err_d = 1'b1;
        end
`endif
      end

      ST_GNT_DL: begin
        if (!bus_lv1_lv2_req_proc_dl) begin
          state_d = ST_TURN;
        end
`ifdef BUS_LV1_LV2_ARB_WDOG_EN
        else if (hold_limit) begin
          state_d    = ST_TURN;
          wdog_err_d = 1'b1;
        end
`endif
      end

      default: begin
        if (bus_lv1_lv2_req_proc_il && bus_lv1_lv2_req_proc_dl) begin
          state_d = last_gnt_dl_q ? ST_GNT_IL : ST_GNT_DL;
        end else if (bus_lv1_lv2_req_proc_il) begin
          state_d = ST_GNT_IL;
        end else if (bus_lv1_lv2_req_proc_dl) begin
          state_d = ST_GNT_DL;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    if ((state_d == ST_GNT_DL) && (state_q != ST_GNT_DL)) begin
      last_gnt_dl_d = 1'b1;
    end else if ((state_d == ST_GNT_IL) && (state_q != ST_GNT_IL)) begin
      last_gnt_dl_d = 1'b0;
    end
  end

`ifdef BUS_LV1_LV2_ARB_WDOG_EN
  // Hold counter: counts granted cycles and restarts at zero on every new grant
  always_comb begin
    hold_cnt_d = '0;
    if ((state_q == ST_GNT_IL) || (state_q == ST_GNT_DL)) begin
      hold_cnt_d = hold_cnt_q + CNT_WID'(1);
    end
  end

  // Hold counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  // Moore output decode from registered state only, so no req-to-gnt combinational path exists
  always_comb begin
    bus_lv1_lv2_gnt_proc_il = (state_q == ST_GNT_IL);
    bus_lv1_lv2_gnt_proc_dl = (state_q == ST_GNT_DL);
    bus_lv1_lv2_gnt_proc    = (state_q == ST_GNT_IL) || (state_q == ST_GNT_DL);
    arb_last_gnt_dl         = last_gnt_dl_q;
`ifdef BUS_LV1_LV2_ARB_WDOG_EN
    arb_wdog_err            = wdog_err_q;
`else
    arb_wdog_err            = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bus_lv1_lv2_arb_proc.sv
// Testbench for bus_lv1_lv2_arb_proc.
// It runs a reference model of the arbitration rules that tracks the
// owner, the round-robin history and the held cycles, and it compares the
// model with the DUT after every clock. The watchdog expectations follow
// BUS_LV1_LV2_ARB_WDOG_EN.
module tb_bus_lv1_lv2_arb_proc;

  localparam int TB_HOLD = 8;
`ifdef BUS_LV1_LV2_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_il = 1'b0;
  logic req_dl = 1'b0;
  logic gnt_il, gnt_dl, gnt_any, last_dl, wdog_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: owner 0 = none, 1 = IL, 2 = DL
  int m_owner = 0;
  bit m_last_dl = 1'b0;
  int m_hold = 0;
  bit m_err = 1'b0;

  wire [4:0] obs_v = {gnt_il, gnt_dl, gnt_any, last_dl, wdog_err};

  bus_lv1_lv2_arb_proc #(.HOLD_MAX(TB_HOLD), .CNT_WID(7)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .bus_lv1_lv2_req_proc_il (req_il),
    .bus_lv1_lv2_req_proc_dl (req_dl),
    .bus_lv1_lv2_gnt_proc_il (gnt_il),
    .bus_lv1_lv2_gnt_proc_dl (gnt_dl),
    .bus_lv1_lv2_gnt_proc    (gnt_any),
    .arb_last_gnt_dl         (last_dl),
    .arb_wdog_err            (wdog_err)
  );

  always #5 clk = ~clk;

  // Absolute time bound so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [4:0] exp_v();
    return {m_owner == 1, m_owner == 2, m_owner != 0, m_last_dl, m_err};
  endfunction

  task automatic model_reset();
    m_owner   = 0;
    m_last_dl = 1'b0;
    m_hold    = 0;
    m_err     = 1'b0;
  endtask

  // Apply one cycle of requests, advance the model, and return 1ns after the clock edge
  task automatic drive(input bit il, input bit dl);
    bit own_req;
    req_il = il;
    req_dl = dl;
    if (m_owner != 0) begin
      own_req = (m_owner == 1) ? il : dl;
      if (!own_req) begin
        m_owner = 0;
        m_err   = 1'b0;
      end else if (WDOG && (m_hold == TB_HOLD - 1)) begin
        m_owner = 0;
        m_err   = 1'b1;
      end else begin
        m_hold++;
        m_err = 1'b0;
      end
    end else begin
      m_err = 1'b0;
      if (il && dl) m_owner = m_last_dl ? 1 : 2;
      else if (il)  m_owner = 1;
      else if (dl)  m_owner = 2;
      if (m_owner != 0) begin
        m_last_dl = (m_owner == 2);
        m_hold    = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_il = 1'b1;
    req_dl = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs_v !== 5'b00000) begin
      n_bad++;
      $display("[TB] FAIL reset_async: got %b want %b", obs_v, 5'b00000);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1);
    n_cmp++;
    if (obs_v !== 5'b01110) begin
      n_bad++;
      $display("[TB] FAIL reset_first_tie: got %b want %b", obs_v, 5'b01110);
    end
  endtask

  task automatic test_single_il();
    int gnt_cycles;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    gnt_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0);
      if (gnt_il) gnt_cycles++;
      n_cmp++;
      if (obs_v !== exp_v()) begin
        n_bad++;
        $display("[TB] FAIL single_il[%0d]: got %b want %b", i, obs_v, exp_v());
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0);
      n_cmp++;
      if (obs_v !== 5'b00000) begin
        n_bad++;
        $display("[TB] FAIL single_il_release[%0d]: got %b want %b", i, obs_v, 5'b00000);
      end
    end
    n_cmp++;
    if (gnt_cycles !== 7) begin
      n_bad++;
      $display("[TB] FAIL single_il_len: got %0d want %0d", gnt_cycles, 7);
    end
  endtask

  task automatic test_handover();
    drive(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    n_cmp++;
    if (obs_v !== 5'b01110) begin
      n_bad++;
      $display("[TB] FAIL handover_dl_hold: got %b want %b", obs_v, 5'b01110);
    end
    drive(1'b1, 1'b0);
    n_cmp++;
    if (obs_v !== 5'b00010) begin
      n_bad++;
      $display("[TB] FAIL handover_turn: got %b want %b", obs_v, 5'b00010);
    end
    drive(1'b1, 1'b0);
    n_cmp++;
    if (obs_v !== 5'b10100) begin
      n_bad++;
      $display("[TB] FAIL handover_il: got %b want %b", obs_v, 5'b10100);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    n_cmp++;
    if (obs_v !== 5'b00000) begin
      n_bad++;
      $display("[TB] FAIL b2b_turn: got %b want %b", obs_v, 5'b00000);
    end
    drive(1'b1, 1'b0);
    n_cmp++;
    if (obs_v !== 5'b10100) begin
      n_bad++;
      $display("[TB] FAIL b2b_regrant: got %b want %b", obs_v, 5'b10100);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0);
    n_cmp++;
    if (obs_v !== exp_v()) begin
      n_bad++;
      $display("[TB] FAIL areset_pre: got %b want %b", obs_v, exp_v());
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt_il, gnt_any} !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL areset_drop: got %b want %b", {gnt_il, gnt_any}, 2'b00);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0);
    n_cmp++;
    if (obs_v !== 5'b10100) begin
      n_bad++;
      $display("[TB] FAIL areset_regrant: got %b want %b", obs_v, 5'b10100);
    end
  endtask

  task automatic test_watchdog();
    int  dl_run;
    int  err_cnt;
    bit  seen_low;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    dl_run   = gnt_dl ? 1 : 0;
    err_cnt  = 0;
    seen_low = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'b1);
      if (gnt_dl && !seen_low) dl_run++;
      else seen_low = 1'b1;
      if (wdog_err) err_cnt++;
      n_cmp++;
      if (obs_v !== exp_v()) begin
        n_bad++;
        $display("[TB] FAIL wdog_step[%0d]: got %b want %b", i, obs_v, exp_v());
      end
    end
    n_cmp++;
    if (dl_run !== (WDOG ? TB_HOLD : 15)) begin
      n_bad++;
      $display("[TB] FAIL wdog_hold_len: got %0d want %0d", dl_run, (WDOG ? TB_HOLD : 15));
    end
    n_cmp++;
    if (err_cnt !== (WDOG ? 1 : 0)) begin
      n_bad++;
      $display("[TB] FAIL wdog_err_pulses: got %0d want %0d", err_cnt, (WDOG ? 1 : 0));
    end
    n_cmp++;
    if ({gnt_il, gnt_dl} !== (WDOG ? 2'b10 : 2'b01)) begin
      n_bad++;
      $display("[TB] FAIL wdog_final_owner: got %b want %b", {gnt_il, gnt_dl}, (WDOG ? 2'b10 : 2'b01));
    end
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit il, dl;
    int overlap;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    il = 1'b0;
    dl = 1'b0;
    overlap = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3, 0) == 0) il = ~il;
      if ($urandom_range(3, 0) == 0) dl = ~dl;
      drive(il, dl);
      if (gnt_il && gnt_dl) overlap++;
      n_cmp++;
      if (obs_v !== exp_v()) begin
        n_bad++;
        $display("[TB] FAIL random[%0d] req=%b%b: got %b want %b", i, il, dl, obs_v, exp_v());
      end
    end
    n_cmp++;
    if (overlap !== 0) begin
      n_bad++;
      $display("[TB] FAIL random_exclusive: got %0d overlapping cycles want 0", overlap);
    end
  endtask

  initial begin
    $display("[TB] starting bus_lv1_lv2_arb_proc bench, watchdog=%0d", WDOG);
    test_reset();
    test_single_il();
    test_handover();
    test_back_to_back();
    test_async_reset();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_lv1_lv2_arb_proc.md
Name: bus_lv1_lv2_arb_proc

Overview:
Per-core arbiter for the shared L1-to-L2 bus (address bus, data bus, lv2_rd) between the L1 instruction cache and the L1 data cache.
- Accepts one bus request from each cache and issues mutually exclusive grants, held for the whole transaction.
- Alternates ownership round-robin and inserts one dead turnaround cycle between owners to avoid bus contention.
- Sits between the two lv1 cache blocks of a core and the lv1/lv2 bus interface.

Parameters:
HOLD_MAX, 64, maximum cycles a grant may be held before the watchdog forces release (used only with the watchdog).
CNT_WID, 7, width of the hold counter; must satisfy 2^CNT_WID > HOLD_MAX.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
bus_lv1_lv2_req_proc_il  input  1  bus request from the L1 instruction cache; held until its transaction completes.
bus_lv1_lv2_req_proc_dl  input  1  bus request from the L1 data cache; same rule.
bus_lv1_lv2_gnt_proc_il  output  1  grant to the L1 instruction cache.
bus_lv1_lv2_gnt_proc_dl  output  1  grant to the L1 data cache.
bus_lv1_lv2_gnt_proc  output  1  OR of both grants; qualifies lv2-side bus activity.
arb_last_gnt_dl  output  1  1 = last completed/current owner is the DL cache, 0 = IL cache.
arb_wdog_err  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- On rst assertion, immediately (not waiting for a clock edge):
  - state = IDLE;
  - both grants and bus_lv1_lv2_gnt_proc = 0;
  - arb_last_gnt_dl = 0 (IL served last, so DL wins the first tie);
  - arb_wdog_err = 0;
  - hold counter = 0.
- Reset mid-transaction drops the grant at once. The requester re-arbitrates after reset release.
- Output timing: all outputs are registered. Grants are a Moore decode of state, with no combinational path from req to gnt.
- States:
  - IDLE: no grant.
  - GNT_IL: gnt_il = 1.
  - GNT_DL: gnt_dl = 1.
  - TURN: no grant; one-cycle turnaround.
- Arbitration in IDLE and TURN:
  - Only one request high: move to that requester's GNT state.
  - Both high: grant the requester that is not arb_last_gnt_dl.
  - Neither high: go to (or stay in) IDLE.
  - TURN never lasts more than one cycle.
- Latency:
  - Request first high in cycle N: grant high in cycle N+1.
  - Owner deasserts request in cycle N: grant low in N+1 (TURN). A pending other requester is granted in N+2.
  - Back-to-back requests from the same cache also pass through TURN. The sole requester is regranted in N+2.
- arb_last_gnt_dl update: set on every entry to GNT_DL, cleared on every entry to GNT_IL.
- In GNT_x: remain while req_x is high. A new request from the other cache is ignored until release.
- Invariants:
  - Both grants high simultaneously is illegal and must never occur.
  - A grant never moves directly between owners without a TURN cycle.
- Request dropped and raised within the same cycle boundary cannot occur (req is registered at the cache). The arbiter treats any low sample as a release.

Optional Feature:
- Macro: BUS_LV1_LV2_ARB_WDOG_EN.
- With the macro defined:
  - The hold counter clears on entry to GNT_IL/GNT_DL and increments each cycle while in a GNT state.
  - When the counter equals HOLD_MAX-1 and the owner's req is still high, the next state is TURN. arb_wdog_err pulses high for exactly that TURN cycle.
  - arb_last_gnt_dl keeps the forced owner, so a pending other requester wins the following arbitration.
  - If req drops in the same cycle the limit is reached, this is a normal release with no error pulse.
- Without the macro: no counter is instantiated, arb_wdog_err is tied 0, and a grant is held indefinitely.

Test Plan:
1. Reset with req_il=1 and req_dl=1 held, release rst at cycle 0 -> gnt_dl=1 at cycle 1, gnt_il=0, arb_last_gnt_dl=1.
2. Only req_il asserted at cycle 5, dropped at cycle 12 -> gnt_il high in cycles 6..12, low at cycle 13; IDLE from cycle 14.
3. DL owns the bus with req_il pending, req_dl dropped at cycle 20 -> cycle 21 no grant (TURN), gnt_il=1 at cycle 22; both grants never high together across a 1000-cycle random req run.
4. rst asserted asynchronously mid-cycle during GNT_IL -> gnt_il and bus_lv1_lv2_gnt_proc fall before the next clk edge; after release with req_il still high, gnt_il=1 one cycle later.
5. With BUS_LV1_LV2_ARB_WDOG_EN and HOLD_MAX=8, req_dl held forever and req_il pending -> gnt_dl high exactly 8 cycles, then one TURN cycle with arb_wdog_err=1, then gnt_il=1; without the macro, gnt_dl stays high and arb_wdog_err stays 0.
